// File: rtl/eep_pkg.sv
// rtl/eep_pkg.sv - shared loader state type and word-packing constant
// Define PROG_LOADER_CHECKSUM_EN to add the CSUM state.
package eep_pkg;

  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
`ifdef PROG_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } load_state_t;

  function automatic logic [8*BYTES_PER_WORD-1:0] pack_word(input logic [7:0] hi,
                                                            input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and code-memory write port of the loader
// master is the loader side, slave is the stream source / code memory side.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 16
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed program image into code memory
// PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and a sticky err output.
module prog_loader
  import eep_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          cpu_hold,
  output logic          done,
`ifdef PROG_LOADER_CHECKSUM_EN
  output logic          err,
`endif
  prog_loader_if.master bus
);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam load_state_t TAIL = CSUM;
`else
  localparam load_state_t TAIL = DONE;
`endif

  load_state_t           state, state_next;
  logic [7:0]            len_lo_q;
  logic [15:0]           len_q;
  logic [15:0]           word_cnt;
  logic [7:0]            lo_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [WORD_WIDTH-1:0] wr_data_q;
  logic                  wr_en_q;
  logic                  done_q;
  logic                  xfer;
  logic                  last_word;
  logic                  load_begin;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
  logic                  err_q;
`endif

  assign xfer       = bus.in_valid & bus.in_ready;
  // word_cnt counts completed words, so the word being finished is the last one
  assign last_word  = (word_cnt + 16'd1) == len_q;
  assign load_begin = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    unique case (state)
      IDLE, DONE: if (start) state_next = LEN_LO;
      LEN_LO: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid)
          state_next = ({bus.in_data, len_lo_q} == 16'd0) ? TAIL : DATA_LO;
      end
      DATA_LO: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = DATA_HI;
      end
      DATA_HI: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = last_word ? TAIL : DATA_LO;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo_q  <= '0;
      len_q     <= '0;
      word_cnt  <= '0;
      lo_q      <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= (state_next == DONE) && (state != DONE);
      if (load_begin) begin
        word_cnt <= '0;
        addr_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_q   <= '0;
        err_q    <= 1'b0;
`endif
      end
      if (xfer) begin
        case (state)
          LEN_LO:  len_lo_q <= bus.in_data;
          LEN_HI:  len_q    <= {bus.in_data, len_lo_q};
          DATA_LO: lo_q     <= bus.in_data;
          DATA_HI: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= WORD_WIDTH'(pack_word(bus.in_data, lo_q));
            addr_q    <= addr_q + 1'b1;
            word_cnt  <= word_cnt + 16'd1;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          CSUM:    err_q    <= (bus.in_data != csum_q);
`endif
          default: ;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        if (state != CSUM) csum_q <= csum_q ^ bus.in_data;
`endif
      end
    end
  end

  // The CPU stays stalled through the final write, which lands on the DONE entry cycle
  assign cpu_hold    = (state != DONE) | wr_en_q;
  assign done        = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err         = err_q;
`endif

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, code-memory word address width.
REQ-002 Parameter WORD_WIDTH, default 16, instruction word width; fixed at 16, two bytes per word.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level-sampled request to begin a load; acted on only in IDLE or DONE.
REQ-006 in_valid  input  1  byte-stream source has a byte.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both 1 on a clk edge.
REQ-009 wr_en  output  1  code-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  ADDR_WIDTH  code-memory write address.
REQ-011 wr_data  output  WORD_WIDTH  code-memory write data.
REQ-012 cpu_hold  output  1  holds the CPU core stalled while 1.
REQ-013 done  output  1  one-cycle pulse on load completion.
REQ-014 err  output  1  sticky checksum error; exists only with the macro (REQ-030).

Function
REQ-015 States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM (macro only), DONE.
REQ-016 Stream format: count N as 16 bits, low byte then high byte; then N words, each low byte then high byte.
REQ-017 IDLE/DONE with start=1 -> LEN_LO; word counter and address counter cleared to 0.
REQ-018 in_ready=1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM; 0 in IDLE/DONE; each state advances only on a handshake.
REQ-019 LEN_HI handshake: N=0 -> DONE (or CSUM with macro); otherwise -> DATA_LO.
REQ-020 DATA_LO handshake latches the low byte; DATA_HI handshake -> registered wr_en=1 next cycle with wr_data={high,low} and wr_addr=current address; the address then increments.
REQ-021 After the Nth word -> DONE (or CSUM); otherwise -> DATA_LO; back-to-back bytes every cycle are sustained with no bubbles.
REQ-022 The address counter wraps modulo 2^ADDR_WIDTH; the word count is the full 16-bit N regardless of ADDR_WIDTH.
REQ-023 cpu_hold=1 from leaving IDLE until entering DONE inclusive of the final wr_en cycle; 0 in DONE.
REQ-024 done pulses for exactly one cycle, on the cycle of entry into DONE, and no earlier than the final wr_en.
REQ-025 start while loading is ignored; start held high in DONE restarts the load the next cycle.

Reset
REQ-026 rst=1 forces immediately: state=IDLE, cpu_hold=1, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, counters=0.
REQ-027 rst mid-load abandons the load without any further wr_en; a partially latched word is discarded.
REQ-028 After reset the CPU stays held until a load completes.

Configuration
REQ-029 Macro PROG_LOADER_CHECKSUM_EN.
REQ-030 With the macro defined:
- A running XOR covers every byte from the count low byte through the last data high byte.
- A single CSUM byte follows the data; on its handshake the FSM -> DONE.
- err is set if the CSUM byte differs from the running XOR; err stays set until the next start or rst.
- done still pulses; cpu_hold still deasserts.
REQ-031 Without the macro there is no CSUM state and no err port; the last word goes straight to DONE.

Structure
REQ-032 The state enum typedef and the byte-per-word constant live in the shared package eep_pkg.
REQ-033 Single flat module with no sub-module; it connects at the eep top to the write port of the code memory.

Verification
REQ-034 Stream 02 00 34 12 78 56 -> wr_en at addr 0 data 0x1234, then addr 1 data 0x5678; one done pulse; cpu_hold falls.
REQ-035 Stream 00 00 -> no wr_en; done one cycle after the LEN_HI handshake; cpu_hold=0.
REQ-036 N=3 with in_valid toggling 1/0 every cycle -> three writes at addresses 0,1,2 with correct data; no duplicated or dropped bytes.
REQ-037 ADDR_WIDTH=2, N=5 -> wr_addr sequence 0,1,2,3,0.
REQ-038 rst asserted after the DATA_LO byte of word 1 -> no further wr_en; cpu_hold=1; state IDLE; a new start plus a full stream loads correctly.
REQ-039 With PROG_LOADER_CHECKSUM_EN, stream 01 00 CD AB and CSUM 0x67 -> err=0; CSUM 0x00 -> err=1; done pulses in both cases.
